// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 default) and colour type for the
// Pacman display path.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Half-open window test used for the sync pulses.
  function automatic logic in_window(input logic [9:0] c, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// Scan-controller bus: coordinates/strobes out to renderers, merged colour
// back in, and the VGA DAC pin group.
interface vga_scan_controller_if;
  logic [9:0] x;
  logic [8:0] y;
  logic       pix_en;
  logic       frame_start;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic       vga_clk;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;

  modport master (
    output x, y, pix_en, frame_start,
    output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b,
    input  r_in, g_in, b_in
  );

  modport slave (
    input  x, y, pix_en, frame_start,
    input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b,
    output r_in, g_in, b_in
  );
endinterface

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register matching sync/blank to renderer latency.
// nxt_o is the value the last stage loads on the next enable.
module vga_sync_delay #(
  parameter int                DEPTH   = 2,
  parameter int                WIDTH   = 3,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] nxt_o
);

  if (DEPTH < 0 || DEPTH > 7) begin : g_bad_depth
    $error("vga_sync_delay: DEPTH must be 0..7");
  end

  if (DEPTH == 0) begin : g_pass
    assign q_o   = d_i;
    assign nxt_o = d_i;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_q <= {DEPTH{RST_VAL}};
      end else if (en_i) begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
    if (DEPTH == 1) begin : g_nxt1
      assign nxt_o = d_i;
    end else begin : g_nxtn
      assign nxt_o = sr_q[DEPTH-2];
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster master: pixel divider, h/v counters, x/y to renderers, and
// latency-matched sync/blank/colour to the DAC.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_scan_controller_if.master vga
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_ACT_L = 10'(H_ACTIVE);
  localparam logic [9:0] H_END_L = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS0_L   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1_L   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);
  localparam logic [9:0] V_END_L = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS0_L   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1_L   = 10'(V_ACTIVE + V_FP + V_SYNC);

  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_scan_controller: PIPE_DELAY must be 0..7");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_scan_controller: CLK_DIV must be >= 1");
  end

  logic [1:0]       rst_sync_q;
  logic             run;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en;
  logic [9:0]       hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  logic             fs_q, fs_d;
  logic             active_d;
  pixel_t           rgb_q, rgb_d;
  logic [2:0]       sync_u, sync_dly, sync_nxt;

  // Release is synchronised so counting starts cleanly two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run    = rst_sync_q[1];
  assign pix_en = run && (div_q == DIV_LAST);

  always_comb begin
    div_d  = div_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (run) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    if (pix_en) begin
      if (hcnt_q == H_END_L) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_END_L) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end

    active_d = (hcnt_d < H_ACT_L) && (vcnt_d < V_ACT_L);
    x_d      = active_d ? hcnt_d : '0;
    y_d      = active_d ? vcnt_d[8:0] : '0;

    fs_d  = fs_q;
    rgb_d = rgb_q;
    if (pix_en) begin
      fs_d  = (hcnt_d == '0) && (vcnt_d == '0);
      // Colour arriving now belongs to the pixel whose blank bit enters the last stage.
      rgb_d = sync_nxt[0] ? pixel_t'{vga.r_in, vga.g_in, vga.b_in} : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
      rgb_q  <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
      rgb_q  <= rgb_d;
    end
  end

  assign sync_u = {~in_window(hcnt_q, HS0_L, HS1_L),
                   ~in_window(vcnt_q, VS0_L, VS1_L),
                   (hcnt_q < H_ACT_L) && (vcnt_q < V_ACT_L)};

  vga_sync_delay #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (reset_n),
    .en_i  (pix_en),
    .d_i   (sync_u),
    .q_o   (sync_dly),
    .nxt_o (sync_nxt)
  );

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.pix_en      = pix_en;
  assign vga.frame_start = fs_q;
  assign vga.vga_clk     = run && (div_q >= DIV_HALF);
  assign vga.vga_hs      = sync_dly[2];
  assign vga.vga_vs      = sync_dly[1];
  assign vga.vga_blank_n = sync_dly[0];
  assign vga.vga_sync_n  = 1'b0;
  assign vga.vga_r       = rgb_q.r;
  assign vga.vga_g       = rgb_q.g;
  assign vga.vga_b       = rgb_q.b;

endmodule
